video_out_fetch: RTL
====================

# video_out_fetch

Display-side counterpart of the capture path. Fetches a frame of packed 8-bit pixels from RAM as a Wishbone master, buffers words in a small internal FIFO, and emits a raster pixel stream with `line_valid`/`frame_valid` timing identical to what the camera delivers to the capture stage. Software programs the frame base address through the Wishbone slave register interface. The block signals by interrupt when that address has been consumed.

## Interface
Parameters:
- `H_ACTIVE`, 640: active pixels per line; multiple of 4.
- `H_TOTAL`, 800: clocks per line, including blanking.
- `V_ACTIVE`, 480: active lines per frame.
- `V_TOTAL`, 525: lines per frame, including blanking.
- `FIFO_DEPTH`, 8: 32-bit words buffered; power of 2, ≥ 2.

Ports:
- `clk` in 1: single clock, also the pixel clock. One clock, no other clock domain.
- `nRST` in 1: asynchronous, active-low reset.
- `wb_reg_data` in 32: frame base address from the slave register; must be word-aligned.
- `wb_reg_ctr` in 1: 1-cycle strobe that latches `wb_reg_data` as the pending base.
- `p_wb_STB_O`, `p_wb_CYC_O` out 1: master strobe and cycle.
- `p_wb_LOCK_O` out 1: constant 0.
- `p_wb_SEL_O` out 4: constant 4'hF while `p_wb_CYC_O` is high; 0 otherwise.
- `p_wb_ADR_O` out 32: read byte address.
- `p_wb_ACK_I`, `p_wb_ERR_I` in 1: cycle termination.
- `p_wb_DAT_I` in 32: read data.
- `line_valid`, `frame_valid` out 1: raster qualifiers.
- `pixel_out` out 8: pixel data.
- `interrupt` out 1: 1-cycle pulse.

## Operation
- **Start-up.** After reset the block is idle: counters stopped, no bus cycles. The first `wb_reg_ctr` sets `running`. The timing generator then starts at h=0, v=V_ACTIVE (blanking), so the FIFO can prefetch before the first active line.
- **Timing generator.** Counters are h in 0..H_TOTAL-1 and v in 0..V_TOTAL-1, advancing every clock while running. Both wrap.
  - `frame_valid` = v < V_ACTIVE.
  - `line_valid` = `frame_valid` and h < H_ACTIVE.
- **Pixel unpacking.** On each active cycle, emit byte k of the current word, with k = h mod 4. Byte order is LSB-first: bits [7:0] first. The FIFO is popped when k=3.
- **Underflow.** If the FIFO is empty when a word is needed, `pixel_out` is 0x00 for those 4 pixels. No word is popped.
- **Frame boundary (h=0, v=V_ACTIVE)**, all in the same cycle:
  - pulse `interrupt`;
  - flush the FIFO;
  - load the current address from the pending base;
  - clear the word counter.
- **Fetch FSM, states IDLE, REQ, DRAIN:**
  - IDLE → REQ when running, the word counter is below H_ACTIVE·V_ACTIVE/4, and the FIFO has a free slot. On entry, assert STB/CYC with ADR = current address.
  - REQ on ACK: push `p_wb_DAT_I`, address += 4, word counter += 1, deassert STB/CYC, go to IDLE.
  - REQ on ERR: push 32'h0 and advance as for ACK, so frame alignment is kept.
  - A frame boundary while in REQ moves the FSM to DRAIN: hold STB/CYC until ACK/ERR, discard the data, then go to IDLE. The new frame's address is already loaded.
- **Base address update.** `wb_reg_ctr` during a frame only updates the pending base. The new base takes effect at the next frame boundary.
- **FIFO corner cases.**
  - Push and pop in the same cycle: allowed, count unchanged.
  - Flush and push in the same cycle: flush wins and the word is dropped.
  - The FIFO never overflows, because a request is issued only when a slot is free.

## Timing
- All outputs are registered. `line_valid`, `frame_valid` and `pixel_out` change together on the same edge.
- Reset values: every output is 0, including ADR, STB, CYC, SEL and `interrupt`. The FSM is in IDLE and the FIFO is empty.
- Reset asserted mid-bus-cycle drops CYC/STB immediately (asynchronous reset).
- Bus cycle timing: STB/CYC rise 1 cycle after the IDLE decision. With a zero-wait slave (ACK in the first STB cycle), the FIFO throughput is 1 word per 2 cycles.
- `interrupt` is high for exactly 1 clock per frame.

## Configuration
- `VIDEO_OUT_UNDERFLOW_CNT_EN`:
  - **Defined:** adds port `underflow_cnt` (out, 16 bits). It increments by 1 per underflowed word, saturates at 16'hFFFF, and clears only on reset.
  - **Undefined:** no port, no counter. Underflow behaviour is otherwise identical.

## Test plan
Bench parameters: H_ACTIVE=8, H_TOTAL=12, V_ACTIVE=2, V_TOTAL=4, FIFO_DEPTH=4.
- **Reset/idle.** Reset, then 50 cycles without `wb_reg_ctr` → all outputs 0 and `p_wb_CYC_O` never asserted.
- **Nominal frame.** Base 0x1000; zero-wait slave returns 0x03020100, 0x07060504, … → ADR sequence 0x1000, 0x1004, 0x1008, 0x100C.
  - Line 0 pixels 0x00..0x07, line 1 pixels 0x08..0x0F.
  - `line_valid` high 8 clocks, low 4 clocks.
  - `frame_valid` high 24 clocks.
- **Slow slave.** ACK delayed 30 cycles → affected 4-pixel groups output 0x00. With the macro defined, `underflow_cnt` matches the missed word count.
- **Bus error.** ERR_I on the word at 0x1004 → pixels 4..7 are 0x00 and the next ADR is 0x1008.
- **Base update.** Write 0x2000 mid-frame → current frame continues from 0x1000. Next frame's first ADR is 0x2000. `interrupt` pulses once, at h=0, v=2.
- **Boundary mid-cycle.** Frame boundary during a pending ACK → the cycle completes and its data is not output. Next frame's pixel 0 comes from the base word.

Source files
------------

// File: rtl/video_out_fetch.sv
// video_out_fetch: Wishbone master that prefetches a packed 8-bit frame into a FIFO and replays it as a raster.
// Defining VIDEO_OUT_UNDERFLOW_CNT_EN adds a saturating underflow_cnt output.
//
// state | meaning
// IDLE  | no bus cycle; waits for a free FIFO slot and an unfinished frame
// REQ   | read cycle in flight; ACK/ERR pushes a word and advances the address
// DRAIN | frame boundary hit mid-cycle; finish the cycle and drop its data
module video_out_fetch #(
    parameter int H_ACTIVE   = 640,
    parameter int H_TOTAL    = 800,
    parameter int V_ACTIVE   = 480,
    parameter int V_TOTAL    = 525,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic [31:0] wb_reg_data,
    input  logic        wb_reg_ctr,
    output logic        p_wb_STB_O,
    output logic        p_wb_CYC_O,
    output logic        p_wb_LOCK_O,
    output logic [3:0]  p_wb_SEL_O,
    output logic [31:0] p_wb_ADR_O,
    input  logic        p_wb_ACK_I,
    input  logic        p_wb_ERR_I,
    input  logic [31:0] p_wb_DAT_I,
    output logic        line_valid,
    output logic        frame_valid,
    output logic [7:0]  pixel_out,
    output logic        interrupt
`ifdef VIDEO_OUT_UNDERFLOW_CNT_EN
    ,
    output logic [15:0] underflow_cnt
`endif
);

    localparam int HW          = $clog2(H_TOTAL);
    localparam int VW          = $clog2(V_TOTAL);
    localparam int AW          = $clog2(FIFO_DEPTH);
    localparam int FRAME_WORDS = H_ACTIVE * V_ACTIVE / 4;
    localparam int WCW         = $clog2(FRAME_WORDS + 1);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
    state_t state, state_nx;

    logic           running;
    logic [31:0]    pending_base, cur_addr;
    logic [HW-1:0]  h;
    logic [VW-1:0]  v;
    logic [WCW-1:0] word_cnt;
    logic [31:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic [AW:0]    count;
    logic           grp_ok_q;

    logic        boundary, active, vis, bus_done, push, pop, empty, full, grp_ok;
    logic [1:0]  k;
    logic [31:0] head;

    assign k        = h[1:0];
    assign vis      = running && (v < VW'(V_ACTIVE));
    assign active   = vis && (h < HW'(H_ACTIVE));
    assign boundary = running && (h == '0) && (v == VW'(V_ACTIVE));
    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign bus_done = p_wb_ACK_I || p_wb_ERR_I;
    // A word landing on the boundary cycle belongs to the old frame: the flush wins.
    assign push     = (state == REQ) && bus_done && !boundary;
    // Underflow is decided once per 4-pixel group, at byte 0.
    assign grp_ok   = (k == 2'd0) ? !empty : grp_ok_q;
    assign pop      = active && (k == 2'd3) && grp_ok;
    assign head     = mem[rd_ptr];

    assign p_wb_LOCK_O = 1'b0;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            running      <= 1'b0;
            pending_base <= '0;
            h            <= '0;
            v            <= VW'(V_ACTIVE);
        end else begin
            if (wb_reg_ctr) begin
                running      <= 1'b1;
                pending_base <= wb_reg_data;
            end
            if (running) begin
                if (h == HW'(H_TOTAL - 1)) begin
                    h <= '0;
                    v <= (v == VW'(V_TOTAL - 1)) ? '0 : v + 1'b1;
                end else begin
                    h <= h + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            cur_addr <= '0;
            word_cnt <= '0;
        end else if (boundary) begin
            cur_addr <= pending_base;
            word_cnt <= '0;
        end else if (push) begin
            cur_addr <= cur_addr + 32'd4;
            word_cnt <= word_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= p_wb_ACK_I ? p_wb_DAT_I : 32'h0;
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (boundary) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (running && !boundary && (word_cnt < WCW'(FRAME_WORDS)) && !full)
                         state_nx = REQ;
            REQ:     if (bus_done)      state_nx = IDLE;
                     else if (boundary) state_nx = DRAIN;
            DRAIN:   if (bus_done)      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            p_wb_STB_O <= 1'b0;
            p_wb_CYC_O <= 1'b0;
            p_wb_SEL_O <= 4'h0;
            p_wb_ADR_O <= '0;
        end else begin
            p_wb_STB_O <= (state_nx != IDLE);
            p_wb_CYC_O <= (state_nx != IDLE);
            p_wb_SEL_O <= (state_nx != IDLE) ? 4'hF : 4'h0;
            if (state == IDLE && state_nx == REQ) p_wb_ADR_O <= cur_addr;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            line_valid  <= 1'b0;
            frame_valid <= 1'b0;
            pixel_out   <= 8'h00;
            interrupt   <= 1'b0;
            grp_ok_q    <= 1'b0;
        end else begin
            frame_valid <= vis;
            line_valid  <= active;
            interrupt   <= boundary;
            pixel_out   <= (active && grp_ok) ? head[{k, 3'b000} +: 8] : 8'h00;
            if (active && k == 2'd0) grp_ok_q <= !empty;
        end
    end

`ifdef VIDEO_OUT_UNDERFLOW_CNT_EN
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST)
            underflow_cnt <= '0;
        else if (active && k == 2'd0 && empty && underflow_cnt != 16'hFFFF)
            underflow_cnt <= underflow_cnt + 1'b1;
    end
`endif

endmodule
